ex_mem_skid: RTL
================

# ex_mem_skid

Parametrised EX→MEM pipeline stage: the next generation of the EX/MEM stage register. It replaces the single bubble/advance register with a 2-entry skid buffer under a valid/ready handshake, plus a synchronous flush. All EX results and memory-access fields pass to MEM with 1-cycle latency at full throughput. When MEM back-pressures, the stage absorbs one extra instruction without a combinational ready path back into EX.

## Interface
- XLEN, 32: width of wdata, mem_addr, reg payload fields
- REG_ADDR_W, 5: destination register address width
- OP_W, 7: opcode field width
- F3_W, 3: funct3 field width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries (branch/exception redirect)
- ex_valid  in  1  EX presents a payload
- ex_ready  out  1  stage can accept; registered, equals "skid entry empty"
- ex_wd, ex_wreg, ex_wdata  in  REG_ADDR_W/1/XLEN  writeback target, enable, data
- ex_op, ex_funct3  in  OP_W/F3_W  memory op decode
- ex_mem_addr, ex_reg  in  XLEN/XLEN  memory address, store data
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes output entry this cycle
- mem_wd, mem_wreg, mem_wdata, mem_op, mem_funct3, mem_mem_addr, mem_reg  out  widths as ex_*  output payload
- stall_req  out  1  ex_valid & ~ex_ready, to the stall controller

## Operation
- Storage: main entry M, which drives the mem_* outputs, and skid entry S. Each holds a full payload and a valid bit.
- Handshake events:
  - accept = ex_valid & ex_ready
  - emit = mem_valid & mem_ready
- FSM, encoded by {M.valid, S.valid}:
  - EMPTY (00):
    - accept → load M, go to ONE
    - no accept → stay
  - ONE (10):
    - accept & emit → load M with the new payload, stay ONE
    - accept & ~emit → load S, go to FULL
    - emit & ~accept → go to EMPTY
    - neither → hold
  - FULL (11):
    - ex_ready=0, so accept is impossible
    - emit → M←S, S cleared, go to ONE
    - no emit → hold both entries
  - State 01 is illegal and must never occur.
- Ordering is strict FIFO: S is never emitted before M.
- Bubble values: whenever M is invalid, its payload is driven to bubble values, and the same applies to S:
  - wd=`Null_RegAddr, wreg=`Disabled
  - wdata, mem_addr, reg = `Zero_Word
  - op=`NOP_CODE, funct3=`Null_FUNCT3
  - Invariant: mem_wreg=0 whenever mem_valid=0, so downstream forwarding never sees a stale write.
- Flush:
  - Highest priority over every other event.
  - Next state is EMPTY with both entries at bubble values.
  - An accept or emit in the flush cycle is discarded: the upstream payload is dropped and the MEM-side handshake is ignored.
- Payload is captured verbatim; no arithmetic or width conversion.

## Timing
- Reset (rst low, asynchronous):
  - state EMPTY, both entries at bubble values
  - mem_valid=0, ex_ready=1, stall_req=0 (given ex_valid=0)
  - All mem_* outputs take their bubble values immediately, without waiting for clk.
- Reset release is synchronous to the next clk edge. The first accept can occur on the first edge with rst high.
- Latency: payload accepted at edge N appears on mem_* after edge N, valid during cycle N+1.
- Throughput: 1 per cycle with mem_ready held at 1. ex_ready never drops in that case.
- ex_ready has no combinational dependence on mem_ready or ex_valid; it depends only on S.valid.
- stall_req is combinational from ex_valid and registered state.
- Back-pressure:
  - mem_ready low for k cycles with EX streaming → exactly one extra entry absorbed.
  - ex_ready falls one cycle after the first stalled accept.
  - After mem_ready returns, ex_ready rises one cycle after the first emit.
- mem_* outputs are held stable while mem_valid=1 and mem_ready=0.
- Reset asserted mid-operation discards all entries with no partial update.

## Test plan
- Reset:
  - Assert rst low mid-stream with ex_valid=1.
  - Required: mem_valid=0, mem_wreg=0, mem_op=`NOP_CODE, ex_ready=1 asynchronously.
  - After release, the first accepted payload appears the next cycle.
- Streaming:
  - 8 back-to-back payloads with wdata=1..8, mem_ready=1.
  - Required: mem_wdata=1..8 on consecutive cycles, 1-cycle latency, ex_ready constant 1.
- Skid fill:
  - Stream A, B, C with mem_ready=0 starting on the cycle A is valid at the output.
  - Required: B held in S, ex_ready=0 and stall_req=1 while C is offered, A stable on mem_*.
  - Release mem_ready → A, B, C emitted in order, with no loss or duplication.
- Flush in FULL:
  - FULL with A in M and B in S, flush=1, ex_valid=1 carrying C.
  - Required: next cycle mem_valid=0, mem_wreg=0, ex_ready=1; A, B and C never appear.
- Simultaneous accept+emit in ONE:
  - Required: state stays ONE, M replaced by the new payload, S never loaded.
- Randomised valid/ready sequence, 10k cycles, against a FIFO scoreboard:
  - Required: in-order delivery, no drops, state 01 never reached.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline stage: a 2-entry skid buffer (main entry M drives MEM, skid entry S)
// under a valid/ready handshake with a synchronous flush. ex_ready is purely registered.
module ex_mem_skid #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 7,
  parameter int F3_W       = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  input  logic [OP_W-1:0]       ex_op_i,
  input  logic [F3_W-1:0]       ex_funct3_i,
  input  logic [XLEN-1:0]       ex_mem_addr_i,
  input  logic [XLEN-1:0]       ex_reg_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic                  mem_wreg_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  output logic [OP_W-1:0]       mem_op_o,
  output logic [F3_W-1:0]       mem_funct3_o,
  output logic [XLEN-1:0]       mem_mem_addr_o,
  output logic [XLEN-1:0]       mem_reg_o,
  output logic                  stall_req_o
);

  localparam logic [REG_ADDR_W-1:0] NULL_REG_ADDR = '0;
  localparam logic                  DISABLED      = 1'b0;
  localparam logic [XLEN-1:0]       ZERO_WORD     = '0;
  localparam logic [OP_W-1:0]       NOP_CODE      = '0;
  localparam logic [F3_W-1:0]       NULL_FUNCT3   = '0;

  localparam int PW = REG_ADDR_W + 1 + XLEN + OP_W + F3_W + XLEN + XLEN;
  localparam logic [PW-1:0] BUBBLE = {NULL_REG_ADDR, DISABLED, ZERO_WORD, NOP_CODE,
                                      NULL_FUNCT3, ZERO_WORD, ZERO_WORD};

  // State encoding is {M.valid, S.valid}; 2'b01 is never produced.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   m_q, m_d;
  logic [PW-1:0]   s_q, s_d;
  logic [PW-1:0]   ex_payload;
  logic            accept;
  logic            emit;

  assign ex_payload = {ex_wd_i, ex_wreg_i, ex_wdata_i, ex_op_i, ex_funct3_i,
                       ex_mem_addr_i, ex_reg_i};

  assign mem_valid_o = state_q[1];
  assign ex_ready_o  = ~state_q[0];
  assign stall_req_o = ex_valid_i & ~ex_ready_o;
  assign accept      = ex_valid_i & ex_ready_o;
  assign emit        = mem_valid_o & mem_ready_i;

  assign {mem_wd_o, mem_wreg_o, mem_wdata_o, mem_op_o, mem_funct3_o,
          mem_mem_addr_o, mem_reg_o} = m_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Invalid entries are always rewritten to BUBBLE so mem_wreg can never leak a stale write.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_d     = ex_payload;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_d = ex_payload;
          end else if (accept) begin
            s_d     = ex_payload;
            state_d = FULL;
          end else if (emit) begin
            m_d     = BUBBLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            m_d     = s_q;
            s_d     = BUBBLE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end
      endcase
    end
  end

endmodule
